sha_msg_pad: RTL

- Upstream feeder for the SHA-256 datapath.
- Accepts an arbitrary-length message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length).
- Emits 16-word blocks on the core's init/vld/din interface and stalls between blocks until the core signals done.
- Lets firmware hash messages of any length without padding them in software.

---
 rtl/sha_msg_pad.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sha_msg_pad.sv
// sha_msg_pad: streams a big-endian 32-bit word message into 16-word SHA-256
// blocks, appending the 0x80 marker, zero fill and 64-bit bit length, and
// pausing after each block until the core reports completion.
module sha_msg_pad #(
  parameter int LEN_W = 32
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start,
  input  logic        s_vld,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_bytes,
  output logic        s_rdy,
  output logic        sha_init,
  output logic        sha_vld,
  output logic [31:0] sha_din,
  input  logic        sha_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    MARK = 3'd2,
    ZERO = 3'd3,
    LEN  = 3'd4,
    WAIT = 3'd5
  } state_t;

  state_t           state;
  state_t           ret_state;
  logic [4:0]       widx;
  logic [LEN_W-1:0] byte_cnt;
  logic             final_blk;

  logic [2:0]       eff_bytes;
  logic [31:0]      keep_mask;
  logic [31:0]      marker;
  logic [31:0]      last_word;
  logic [4:0]       nidx;
  logic             xfer;
  logic [63:0]      bit_len;

  // After a padding word lands at index nidx-1, pick where the block goes next:
  // a full block waits for the core, index 14 starts the length, else keep zeroing.
  function automatic state_t pad_state(input logic [4:0] n);
    if (n == 5'd16)
      return WAIT;
    else if (n == 5'd14)
      return LEN;
    else
      return ZERO;
  endfunction

  // Decode the final-word byte count into a keep mask and marker position.
  always_comb begin
    eff_bytes = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    keep_mask = 32'hFFFF_FFFF;
    marker    = 32'h0000_0000;
    case (eff_bytes)
      3'd0: begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
      3'd1: begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
      3'd2: begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
      3'd3: begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
      default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h0000_0000; end
    endcase
    last_word = (s_data & keep_mask) | marker;
    nidx      = widx + 5'd1;
    xfer      = s_vld & s_rdy & (state == DATA);
  end

  // Message bit length: byte count times eight, zero-extended to 64 bits.
  assign bit_len = {{(64 - LEN_W){1'b0}}, byte_cnt} << 3;

  // Padding FSM with all handshake and core-facing outputs registered.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      ret_state <= IDLE;
      widx      <= 5'd0;
      byte_cnt  <= '0;
      final_blk <= 1'b0;
      s_rdy     <= 1'b0;
      sha_init  <= 1'b0;
      sha_vld   <= 1'b0;
      sha_din   <= 32'h0;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= DATA;
      ret_state <= DATA;
      widx      <= 5'd0;
      byte_cnt  <= '0;
      final_blk <= 1'b0;
      s_rdy     <= 1'b1;
      sha_init  <= 1'b1;
      sha_vld   <= 1'b0;
      sha_din   <= 32'h0;
      busy      <= 1'b1;
    end else begin
      sha_init <= 1'b0;
      sha_vld  <= 1'b0;
      case (state)
        IDLE: begin
          s_rdy <= 1'b0;
        end
        DATA: begin
          if (xfer) begin
            sha_vld <= 1'b1;
            widx    <= (nidx == 5'd16) ? 5'd0 : nidx;
            if (!s_last) begin
              sha_din  <= s_data;
              byte_cnt <= byte_cnt + LEN_W'(4);
              if (nidx == 5'd16) begin
                state     <= WAIT;
                ret_state <= DATA;
                s_rdy     <= 1'b0;
              end
            end else begin
              byte_cnt <= byte_cnt + LEN_W'(eff_bytes);
              s_rdy    <= 1'b0;
              if (eff_bytes == 3'd4) begin
                sha_din <= s_data;
                if (nidx == 5'd16) begin
                  state     <= WAIT;
                  ret_state <= MARK;
                end else begin
                  state <= MARK;
                end
              end else begin
                sha_din   <= last_word;
                state     <= pad_state(nidx);
                ret_state <= ZERO;
              end
            end
          end
        end
        MARK: begin
          sha_vld   <= 1'b1;
          sha_din   <= 32'h8000_0000;
          widx      <= (nidx == 5'd16) ? 5'd0 : nidx;
          state     <= pad_state(nidx);
          ret_state <= ZERO;
        end
        ZERO: begin
          sha_vld   <= 1'b1;
          sha_din   <= 32'h0000_0000;
          widx      <= (nidx == 5'd16) ? 5'd0 : nidx;
          state     <= pad_state(nidx);
          ret_state <= ZERO;
        end
        LEN: begin
          sha_vld <= 1'b1;
          if (widx == 5'd14) begin
            sha_din <= bit_len[63:32];
            widx    <= 5'd15;
          end else begin
            sha_din   <= bit_len[31:0];
            widx      <= 5'd0;
            state     <= WAIT;
            final_blk <= 1'b1;
          end
        end
        WAIT: begin
          if (sha_done) begin
            if (final_blk) begin
              state     <= IDLE;
              final_blk <= 1'b0;
              busy      <= 1'b0;
              s_rdy     <= 1'b0;
            end else begin
              state <= ret_state;
              s_rdy <= (ret_state == DATA);
            end
          end
        end
        default: begin
          state <= IDLE;
          s_rdy <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
